// File: rtl/clock_set_controller.sv
// clock_set_controller
// Front end for a digital clock's three setting buttons (mode / inc / dec):
// synchronizes and debounces the raw buttons, walks the RUN -> SET_HOUR ->
// SET_MIN -> SET_SEC -> RUN setting FSM, and generates the 1 Hz timekeeping
// strobe, the per-field step pulses and the blinking blank mask.
// Optional feature macro: AUTO_REPEAT_EN -- a held inc/dec button in a set
// state keeps stepping after REPEAT_DELAY cycles, then every REPEAT_RATE cycles.
module clock_set_controller #(
  parameter int DEB_CYCLES   = 1000000,
  parameter int TICK_DIV     = 50000000,
  parameter int BLINK_DIV    = 12500000,
  parameter int REPEAT_DELAY = 25000000,
  parameter int REPEAT_RATE  = 5000000
) (
  input  logic       clk50,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       btn_dec,
  output logic       tick_1hz,
  output logic       disable_clk,
  output logic [2:0] inc_pulse,
  output logic [2:0] dec_pulse,
  output logic [2:0] blank,
  output logic [1:0] mode
);

  // Button lanes inside the packed button vectors
  localparam int BM = 0;
  localparam int BI = 1;
  localparam int BD = 2;

  localparam int DEB_W   = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam int TICK_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_HOUR = 2'd1,
    SET_MIN  = 2'd2,
    SET_SEC  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [2:0]         sync1_q, sync2_q;
  logic [2:0]         deb_q, debDly_q, pressEv_q;
  logic [DEB_W-1:0]   debCnt_q [3];
  logic [2:0]         stepEv;
  logic [2:0]         fieldMask;
  logic [2:0]         incPulse_d, incPulse_q;
  logic [2:0]         decPulse_d, decPulse_q;
  logic [TICK_W-1:0]  tickCnt_d, tickCnt_q;
  logic               tick_d, tick_q;
  logic [BLINK_W-1:0] blinkCnt_d, blinkCnt_q;
  logic               phase_d, phase_q;

  // Two-flop synchronizer for the raw buttons (idle level is released = 1)
  always_ff @(posedge clk50 or negedge reset) begin
    if (!reset) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= {btn_dec, btn_inc, btn_mode};
      sync2_q <= sync1_q;
    end
  end

  // Debounce: adopt the synchronized level after DEB_CYCLES consecutive
  // differing cycles, then emit a one-cycle event on a released->pressed change
  always_ff @(posedge clk50 or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 3; i++) debCnt_q[i] <= '0;
      deb_q     <= '1;
      debDly_q  <= '1;
      pressEv_q <= '0;
    end else begin
      debDly_q  <= deb_q;
      pressEv_q <= debDly_q & ~deb_q;
      for (int i = 0; i < 3; i++) begin
        if (sync2_q[i] != deb_q[i]) begin
          if (debCnt_q[i] == DEB_W'(DEB_CYCLES - 1)) begin
            deb_q[i]    <= sync2_q[i];
            debCnt_q[i] <= '0;
          end else begin
            debCnt_q[i] <= debCnt_q[i] + 1'b1;
          end
        end else begin
          debCnt_q[i] <= '0;
        end
      end
    end
  end

`ifdef AUTO_REPEAT_EN
  localparam int RPT_W = $clog2(REPEAT_DELAY + 1);

  logic [RPT_W-1:0] rptCnt_q [2];
  logic [RPT_W-1:0] rptCnt_d [2];
  logic [1:0]       rptHit;

  // Hold timers for inc (0) and dec (1): started by the press event, they fire
  // after REPEAT_DELAY cycles and then reload so the next hit is REPEAT_RATE later
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      rptHit[i]   = 1'b0;
      rptCnt_d[i] = '0;
      if ((state_q == RUN) || deb_q[i+1]) begin
        rptCnt_d[i] = '0;
      end else if (pressEv_q[i+1]) begin
        rptCnt_d[i] = RPT_W'(1);
      end else if (rptCnt_q[i] == RPT_W'(REPEAT_DELAY)) begin
        rptHit[i]   = 1'b1;
        rptCnt_d[i] = RPT_W'(REPEAT_DELAY - REPEAT_RATE + 1);
      end else if (rptCnt_q[i] != '0) begin
        rptCnt_d[i] = rptCnt_q[i] + 1'b1;
      end
    end
  end

  // Hold timer registers
  always_ff @(posedge clk50 or negedge reset) begin
    if (!reset) begin
      rptCnt_q[0] <= '0;
      rptCnt_q[1] <= '0;
    end else begin
      rptCnt_q[0] <= rptCnt_d[0];
      rptCnt_q[1] <= rptCnt_d[1];
    end
  end

  assign stepEv = pressEv_q | {rptHit, 1'b0};
`else
  assign stepEv = pressEv_q;
`endif

  // FSM state register
  always_ff @(posedge clk50 or negedge reset) begin
    if (!reset) state_q <= RUN;
    else        state_q <= state_d;
  end

  // FSM next state: one step around the ring per mode press
  always_comb begin
    state_d = state_q;
    if (stepEv[BM]) begin
      case (state_q)
        RUN:      state_d = SET_HOUR;
        SET_HOUR: state_d = SET_MIN;
        SET_MIN:  state_d = SET_SEC;
        SET_SEC:  state_d = RUN;
        default:  state_d = RUN;
      endcase
    end
  end

  // FSM outputs: field selection, step pulse requests, freeze and blank mask;
  // a mode press or a simultaneous inc+dec press cancels the step
  always_comb begin
    case (state_q)
      SET_HOUR: fieldMask = 3'b100;
      SET_MIN:  fieldMask = 3'b010;
      SET_SEC:  fieldMask = 3'b001;
      default:  fieldMask = 3'b000;
    endcase
    incPulse_d  = (stepEv[BI] && !stepEv[BD] && !stepEv[BM]) ? fieldMask : 3'b000;
    decPulse_d  = (stepEv[BD] && !stepEv[BI] && !stepEv[BM]) ? fieldMask : 3'b000;
    disable_clk = (state_q != RUN);
    mode        = state_q;
    blank       = phase_q ? fieldMask : 3'b000;
  end

  // Step pulse registers
  always_ff @(posedge clk50 or negedge reset) begin
    if (!reset) begin
      incPulse_q <= '0;
      decPulse_q <= '0;
    end else begin
      incPulse_q <= incPulse_d;
      decPulse_q <= decPulse_d;
    end
  end

  assign inc_pulse = incPulse_q;
  assign dec_pulse = decPulse_q;

  // Tick divider: runs only while RUN is both current and next, so it restarts
  // from 0 on re-entry and never strobes on the edge that leaves RUN
  always_comb begin
    tickCnt_d = tickCnt_q + 1'b1;
    tick_d    = 1'b0;
    if ((state_q != RUN) || (state_d != RUN)) begin
      tickCnt_d = '0;
    end else if (tickCnt_q == TICK_W'(TICK_DIV - 1)) begin
      tickCnt_d = '0;
      tick_d    = 1'b1;
    end
  end

  // Tick divider registers
  always_ff @(posedge clk50 or negedge reset) begin
    if (!reset) begin
      tickCnt_q <= '0;
      tick_q    <= 1'b0;
    end else begin
      tickCnt_q <= tickCnt_d;
      tick_q    <= tick_d;
    end
  end

  assign tick_1hz = tick_q;

  // Blink phase: toggles every BLINK_DIV cycles, forced visible on any mode
  // change or step so the user always sees the value just edited
  always_comb begin
    blinkCnt_d = blinkCnt_q + 1'b1;
    phase_d    = phase_q;
    if ((state_d != state_q) || (incPulse_d != 3'b000) || (decPulse_d != 3'b000)) begin
      blinkCnt_d = '0;
      phase_d    = 1'b0;
    end else if (blinkCnt_q == BLINK_W'(BLINK_DIV - 1)) begin
      blinkCnt_d = '0;
      phase_d    = ~phase_q;
    end
  end

  // Blink registers
  always_ff @(posedge clk50 or negedge reset) begin
    if (!reset) begin
      blinkCnt_q <= '0;
      phase_q    <= 1'b0;
    end else begin
      blinkCnt_q <= blinkCnt_d;
      phase_q    <= phase_d;
    end
  end

endmodule

// File: tb/tb_clock_set_controller.sv
// tb_clock_set_controller
// Randomized button transactions against an event-level reference model:
// a press held for at least DEB cycles produces its event DEB+3 edges after
// the first low sample; the model then applies the mode/step rules and derives
// tick and blink from the edges at which RUN was entered or blink was restarted.
module tb_clock_set_controller;

  localparam int DEB    = 4;
  localparam int TICK   = 10;
  localparam int BLINK  = 8;
  localparam int RDELAY = 20;
  localparam int RRATE  = 5;

  logic       clk50    = 1'b0;
  logic       reset    = 1'b1;
  logic       btn_mode = 1'b1;
  logic       btn_inc  = 1'b1;
  logic       btn_dec  = 1'b1;
  logic       tick_1hz;
  logic       disable_clk;
  logic [2:0] inc_pulse;
  logic [2:0] dec_pulse;
  logic [2:0] blank;
  logic [1:0] mode;

  clock_set_controller #(
    .DEB_CYCLES  (DEB),
    .TICK_DIV    (TICK),
    .BLINK_DIV   (BLINK),
    .REPEAT_DELAY(RDELAY),
    .REPEAT_RATE (RRATE)
  ) dut (
    .clk50      (clk50),
    .reset      (reset),
    .btn_mode   (btn_mode),
    .btn_inc    (btn_inc),
    .btn_dec    (btn_dec),
    .tick_1hz   (tick_1hz),
    .disable_clk(disable_clk),
    .inc_pulse  (inc_pulse),
    .dec_pulse  (dec_pulse),
    .blank      (blank),
    .mode       (mode)
  );

  always #10 clk50 = ~clk50;

  int cyc      = 0;
  int checks   = 0;
  int passes   = 0;
  int mMode    = 0;
  int runStart = 0;
  int blinkRef = 0;
  bit inReset  = 1'b1;
  int qMode[$];
  int qInc[$];
  int qDec[$];

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed == expected) passes++;
    else $display("[TB] FAIL %s at edge %0d: got %0d, expected %0d", tag, cyc, observed, expected);
  endtask

  task automatic checkAll(input int eMode, input int eTick, input int eInc, input int eDec, input int eBlank);
    checkOutput("mode", int'(mode), eMode);
    checkOutput("disable_clk", int'(disable_clk), (eMode != 0) ? 1 : 0);
    checkOutput("tick_1hz", int'(tick_1hz), eTick);
    checkOutput("inc_pulse", int'(inc_pulse), eInc);
    checkOutput("dec_pulse", int'(dec_pulse), eDec);
    checkOutput("blank", int'(blank), eBlank);
  endtask

  // One clock edge: update the model for this edge, then compare every output
  task automatic advance();
    bit evM, evI, evD;
    int oldMode, expInc, expDec, expTick, expBlank, phase;
    @(posedge clk50);
    #1;
    cyc++;
    expInc = 0; expDec = 0; expTick = 0; expBlank = 0;
    if (inReset) begin
      mMode = 0;
    end else begin
      evM = 1'b0; evI = 1'b0; evD = 1'b0;
      if (qMode.size() > 0 && qMode[0] == cyc) begin evM = 1'b1; void'(qMode.pop_front()); end
      if (qInc.size() > 0 && qInc[0] == cyc) begin evI = 1'b1; void'(qInc.pop_front()); end
      if (qDec.size() > 0 && qDec[0] == cyc) begin evD = 1'b1; void'(qDec.pop_front()); end
      oldMode = mMode;
      if (evM) mMode = (mMode + 1) % 4;
      else if (evI && evD) begin end
      else if (evI && mMode != 0) expInc = 1 << (3 - mMode);
      else if (evD && mMode != 0) expDec = 1 << (3 - mMode);
      if (mMode != oldMode || expInc != 0 || expDec != 0) blinkRef = cyc;
      if (mMode == 0 && oldMode != 0) runStart = cyc;
      if (mMode == 0 && oldMode == 0 && cyc > runStart && ((cyc - runStart) % TICK) == 0) expTick = 1;
      phase = ((cyc - blinkRef) / BLINK) % 2;
      expBlank = (mMode == 0) ? 0 : (phase << (3 - mMode));
    end
    checkAll(mMode, expTick, expInc, expDec, expBlank);
  endtask

  // Queue the events a press produces when its first low sample is edge s
  task automatic schedulePress(input bit m, input bit i, input bit d, input int s, input int len);
    int first;
    if (len < DEB) return;
    first = s + DEB + 3;
    if (m) qMode.push_back(first);
    if (i) qInc.push_back(first);
    if (d) qDec.push_back(first);
`ifdef AUTO_REPEAT_EN
    for (int p = first + RDELAY; p <= s + len + DEB + 1; p += RRATE) begin
      if (i) qInc.push_back(p);
      if (d) qDec.push_back(p);
    end
`endif
  endtask

  task automatic applyStimulus(input bit m, input bit i, input bit d, input int len, input int gap);
    schedulePress(m, i, d, cyc + 1, len);
    btn_mode = !m;
    btn_inc  = !i;
    btn_dec  = !d;
    repeat (len) advance();
    btn_mode = 1'b1;
    btn_inc  = 1'b1;
    btn_dec  = 1'b1;
    repeat (gap) advance();
  endtask

  task automatic doReset(input int n);
    reset   = 1'b0;
    inReset = 1'b1;
    qMode.delete();
    qInc.delete();
    qDec.delete();
    mMode = 0;
    #1;
    checkAll(0, 0, 0, 0, 0);
    repeat (n) advance();
    reset    = 1'b1;
    inReset  = 1'b0;
    runStart = cyc;
    blinkRef = cyc;
  endtask

  initial begin
    int kind, len, gap, b, s;
    #1;
    doReset(3);
    $display("[TB] free-running RUN");
    repeat (25) advance();
    $display("[TB] short glitch then four mode presses");
    applyStimulus(1'b1, 1'b0, 1'b0, DEB - 1, 12);
    for (int k = 0; k < 4; k++) applyStimulus(1'b1, 1'b0, 1'b0, DEB + 2, 14);
    $display("[TB] random transactions");
    for (int n = 0; n < 60; n++) begin
      kind = $urandom_range(0, 5);
      gap  = $urandom_range(DEB + 4, DEB + 14);
      b    = $urandom_range(0, 2);
      case (kind)
        0: begin len = $urandom_range(DEB, DEB + 8); applyStimulus(1'b1, 1'b0, 1'b0, len, gap); end
        1: begin len = $urandom_range(DEB, 40);      applyStimulus(1'b0, 1'b1, 1'b0, len, gap); end
        2: begin len = $urandom_range(DEB, 40);      applyStimulus(1'b0, 1'b0, 1'b1, len, gap); end
        3: begin len = $urandom_range(DEB, 40);      applyStimulus(1'b0, 1'b1, 1'b1, len, gap); end
        4: begin len = $urandom_range(DEB, DEB + 8); applyStimulus(1'b1, b == 0, b != 0, len, gap); end
        default: begin
          len = $urandom_range(1, DEB - 1);
          applyStimulus(b == 0, b == 1, b == 2, len, gap);
        end
      endcase
    end
    $display("[TB] reset during a held dec, mode held through reset release");
    for (int k = 0; k < 4 && mMode == 0; k++) applyStimulus(1'b1, 1'b0, 1'b0, DEB + 2, 12);
    s = cyc + 1;
    schedulePress(1'b0, 1'b0, 1'b1, s, 30);
    btn_dec = 1'b0;
    repeat (30) advance();
    btn_dec  = 1'b1;
    btn_mode = 1'b0;
    doReset(4);
    schedulePress(1'b1, 1'b0, 1'b0, cyc + 1, DEB + 6);
    repeat (DEB + 6) advance();
    btn_mode = 1'b1;
    repeat (12) advance();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/clock_set_controller.md
CLOCK_SET_CONTROLLER -- requirements
Module: clock_set_controller

Interface
REQ-001 The block SHALL have parameter DEB_CYCLES, default 1000000, giving the debounce stable time in clk50 cycles (20 ms).
REQ-002 The block SHALL have parameter TICK_DIV, default 50000000, giving the clk50 cycles per 1 Hz timekeeping tick.
REQ-003 The block SHALL have parameter BLINK_DIV, default 12500000, giving the clk50 cycles per blink phase toggle.
REQ-004 The block SHALL have parameter REPEAT_DELAY, default 25000000, giving the hold time before the first auto-repeat.
REQ-005 The block SHALL have parameter REPEAT_RATE, default 5000000, giving the interval between auto-repeats.
REQ-006 The block SHALL have port clk50, input, 1 bit, the 50 MHz system clock; all state SHALL update on its rising edge.
REQ-007 The block SHALL have port reset, input, 1 bit, the asynchronous active-low reset.
REQ-008 The block SHALL have ports btn_mode, btn_inc and btn_dec, each input, 1 bit: raw asynchronous pushbuttons, low = pressed.
REQ-009 The block SHALL have port tick_1hz, output, 1 bit: a one-cycle timekeeping strobe to the seconds counter.
REQ-010 The block SHALL have port disable_clk, output, 1 bit: high while in any set state, freezing all time counters.
REQ-011 The block SHALL have ports inc_pulse and dec_pulse, each output, 3 bits, one-cycle step pulses: bit0 sec, bit1 min, bit2 hour.
REQ-012 The block SHALL have port blank, output, 3 bits, the per-field display blank mask, using the same bit order.
REQ-013 The block SHALL have port mode, output, 2 bits: 0 RUN, 1 SET_HOUR, 2 SET_MIN, 3 SET_SEC.

Function
REQ-014 Each button SHALL pass through a 2-flop synchronizer.
REQ-015 The debounced state of a button SHALL change only after the synchronized input differs from it for DEB_CYCLES consecutive cycles.
REQ-016 A press event SHALL be a one-cycle pulse on a debounced released-to-pressed transition; a release SHALL produce no event.
REQ-017 For a raw low held from edge 0, the resulting output pulse SHALL assert exactly DEB_CYCLES+3 rising edges later.
REQ-018 The FSM SHALL advance RUN->SET_HOUR->SET_MIN->SET_SEC->RUN, one step per btn_mode press event.
REQ-019 In RUN, inc and dec press events SHALL be ignored; disable_clk=0; blank=000.
REQ-020 In SET_x, an inc press event SHALL pulse inc_pulse for field x only, and a dec press event SHALL pulse dec_pulse for field x only; disable_clk=1.
REQ-021 If inc and dec press events occur in the same cycle, both SHALL be dropped.
REQ-022 If a mode press event coincides with an inc or dec press event, the mode transition SHALL be taken and the step dropped.
REQ-023 In RUN, the tick counter SHALL count 0..TICK_DIV-1, and tick_1hz SHALL be high for the one cycle when the counter wraps.
REQ-024 In set states, the tick counter SHALL be held at 0 and tick_1hz SHALL be 0.
REQ-025 On return to RUN, the first tick SHALL occur TICK_DIV cycles later.
REQ-026 The blink phase SHALL toggle every BLINK_DIV cycles and SHALL reset to 0 (visible) on every mode change and on every inc or dec pulse.
REQ-027 In SET_x, blank for field x SHALL equal the blink phase, and all other bits SHALL be 0.
REQ-028 inc_pulse and dec_pulse SHALL never have more than one bit set, and SHALL never both be nonzero in the same cycle.

Reset
REQ-029 While reset=0, the block SHALL be in RUN with mode=0, tick_1hz=0, disable_clk=0, inc_pulse=dec_pulse=000 and blank=000.
REQ-030 While reset=0, all counters SHALL be 0, synchronizers SHALL be 1, and debounced states SHALL be released.
REQ-031 A reset asserted in a set state SHALL abort to RUN, and no pending pulse SHALL be emitted after release.
REQ-032 A button held through reset release SHALL register as one press only after DEB_CYCLES.

Configuration
REQ-033 With AUTO_REPEAT_EN defined, a debounced inc or dec held in a set state SHALL emit a repeat pulse after REPEAT_DELAY cycles of hold, then one every REPEAT_RATE cycles until release.
REQ-034 Under AUTO_REPEAT_EN, holding btn_mode SHALL never repeat.
REQ-035 Without AUTO_REPEAT_EN, exactly one pulse SHALL be emitted per press, and the repeat counters SHALL be absent.

Verification
REQ-036 Scenario 1: DEB_CYCLES=4, TICK_DIV=10, RUN -> tick_1hz pulses every 10 cycles, disable_clk=0.
REQ-037 Scenario 2: btn_mode low for 3 cycles then high -> no mode change, since the glitch is shorter than debounce.
REQ-038 Scenario 3: four btn_mode presses -> mode 1,2,3,0; disable_clk high in modes 1-3; first tick 10 cycles after re-entering RUN.
REQ-039 Scenario 4: SET_MIN with btn_inc held from edge 0 -> inc_pulse=010 at edge 7 only; btn_inc and btn_dec pressed together -> no pulse.
REQ-040 Scenario 5: BLINK_DIV=8 in SET_SEC -> blank toggles 000/001 every 8 cycles and returns to 000 on an inc pulse.
REQ-041 Scenario 6: with AUTO_REPEAT_EN, REPEAT_DELAY=20, REPEAT_RATE=5, btn_dec held -> dec pulses at edge 7, 27, 32, 37...; reset mid-hold -> all outputs 0, mode=0.
